// File: rtl/button_event_pkg.sv
// Shared types and default constants for the button event decoder.
package button_event_pkg;

    // Hold-tracking FSM states
    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;

    // Default hold time to long_press, auto-repeat spacing and counter width
    localparam int DEF_LONG_CYCLES   = 1000;
    localparam int DEF_REPEAT_CYCLES = 200;
    localparam int DEF_CNT_W         = 17;

endpackage

// File: rtl/button_event_edge.sv
// btn_edge: registers the debounced level and strobes its rising/falling edges.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic rise,
    output logic fall
);

    logic clean_q;

    // Previous-cycle copy of the button level; reset to 0 so a held button
    // is seen as a fresh rise once reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= 1'b0;
        end else begin
            clean_q <= clean;
        end
    end

    // Edge strobes, consumed by the registered FSM in the parent
    always_comb begin
        rise = clean & ~clean_q;
        fall = ~clean & clean_q;
    end

endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release,
// short/long press and auto-repeat pulses. All outputs are registered.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic press,
    output logic release_p,
    output logic short_press,
    output logic long_press,
    output logic repeat_p,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rise, fall;
    logic             press_nx, release_nx, short_nx, long_nx, repeat_nx, held_nx;

    btn_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .clean (clean),
        .rise  (rise),
        .fall  (fall)
    );

    // State, hold counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            release_p   <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_p    <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            press       <= press_nx;
            release_p   <= release_nx;
            short_press <= short_nx;
            long_press  <= long_nx;
            repeat_p    <= repeat_nx;
            held        <= held_nx;
        end
    end

    // Next-state, counter and pulse decode; a fall always beats a threshold
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        short_nx   = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    press_nx = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    release_nx = 1'b1;
                    short_nx   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nx = LONG_HELD;
                    cnt_nx   = '0;
                    long_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    release_nx = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_nx    = '0;
                    repeat_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        held_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clean;
    logic press, release_p, short_press, long_press, repeat_p, held;

    button_event #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R),
        .CNT_W         (17)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clean       (clean),
        .press       (press),
        .release_p   (release_p),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_p    (repeat_p),
        .held        (held)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: hold age measured in edges since the rise edge.
    // Output vector order: {press, release_p, short_press, long_press, repeat_p, held}
    logic       m_prev;
    int         m_edge;
    int         m_rise_edge;
    logic [5:0] m_exp;

    typedef struct {
        logic       c;
        logic [5:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [5:0] dut_out();
        return {press, release_p, short_press, long_press, repeat_p, held};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (press,rel,short,long,rep,held) t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_excl(input string name);
        logic [3:0] p;
        p = {press, long_press, repeat_p, release_p};
        tests++;
        if (!$onehot0(p) || (short_press && !release_p)) begin
            fails++;
            $display("FAIL %s/exclusive: got pulses %b short %b expected at most one, short only with release",
                     name, p, short_press);
        end
    endtask

    task automatic model_edge(input logic c);
        int a;
        a     = m_edge - m_rise_edge;
        m_exp = '0;
        if (c && !m_prev) begin
            m_exp[5]    = 1'b1;
            m_rise_edge = m_edge;
        end else if (!c && m_prev) begin
            m_exp[4] = 1'b1;
            m_exp[3] = (a <= L);
        end else if (c && m_prev) begin
            m_exp[2] = (a == L);
            m_exp[1] = (a > L) && (((a - L) % R) == 0);
        end
        m_exp[0] = c;
        m_prev   = c;
        m_edge++;
    endtask

    // Called at a falling edge: drive, clock, compare at the next falling edge
    task automatic cycle(input logic c, input string name);
        clean = c;
        @(posedge clk);
        model_edge(c);
        @(negedge clk);
        check({name, "/model"}, dut_out(), m_exp);
        check_excl(name);
    endtask

    // Asynchronous reset pulse lasting two clock edges
    task automatic do_reset(input logic c, input string name);
        clean = c;
        #2 rst_n = 1'b0;
        #1 check({name, "/async"}, dut_out(), 6'b0);
        m_prev = 1'b0;
        m_exp  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({name, "/during"}, dut_out(), 6'b0);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic c, input logic [5:0] e, input string n);
        vec_t v;
        v.c    = c;
        v.exp  = e;
        v.name = n;
        tbl.push_back(v);
    endfunction

    initial begin
        int   long_at;
        int   rep_at[$];
        logic lvl;

        m_prev      = 1'b0;
        m_edge      = 0;
        m_rise_edge = 0;
        m_exp       = '0;
        clean       = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_state", dut_out(), 6'b0);
        repeat (2) @(negedge clk);
        check("reset_hold", dut_out(), 6'b0);
        rst_n = 1'b1;

        // Directed vector table
        add(1, 6'b100001, "short"); add(1, 6'b000001, "short"); add(1, 6'b000001, "short");
        add(0, 6'b011000, "short"); add(0, 6'b000000, "short"); add(0, 6'b000000, "short");
        add(1, 6'b100001, "b2b");   add(0, 6'b011000, "b2b");   add(1, 6'b100001, "b2b");
        add(0, 6'b011000, "b2b");   add(0, 6'b000000, "b2b");
        add(1, 6'b100001, "tie");
        for (int i = 0; i < L - 1; i++) add(1, 6'b000001, "tie");
        add(0, 6'b011000, "tie");   add(0, 6'b000000, "tie");
        add(1, 6'b100001, "past_tie");
        for (int i = 0; i < L - 1; i++) add(1, 6'b000001, "past_tie");
        add(1, 6'b000101, "past_tie"); add(0, 6'b010000, "past_tie"); add(0, 6'b000000, "past_tie");

        foreach (tbl[i]) begin
            cycle(tbl[i].c, tbl[i].name);
            check({tbl[i].name, "/table"}, dut_out(), tbl[i].exp);
        end

        // Long hold of 20 cycles: long at +8, repeats at +12 and +16
        long_at = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, "long");
            if (long_press) long_at = i;
            if (repeat_p) rep_at.push_back(i);
        end
        check_int("long/long_at", long_at, L);
        check_int("long/repeat_count", rep_at.size(), 2);
        check_int("long/repeat1_at", (rep_at.size() > 0) ? rep_at[0] : -1, L + R);
        check_int("long/repeat2_at", (rep_at.size() > 1) ? rep_at[1] : -1, L + 2 * R);
        cycle(1'b0, "long_rel");
        check("long_rel/explicit", {release_p, short_press}, {4'b0, 2'b10});
        cycle(1'b0, "idle");

        // Reset at cycle 10 of a hold, clean stays high across it
        for (int i = 0; i < 10; i++) cycle(1'b1, "midreset");
        do_reset(1'b1, "midreset");
        cycle(1'b1, "midreset_repress");
        check("midreset/press_again", {5'b0, press}, 6'b000001);
        cycle(1'b1, "midreset_hold");
        cycle(1'b0, "midreset_rel");
        cycle(1'b0, "idle");

        // Random level runs against the model
        lvl = 1'b0;
        for (int k = 0; k < 60; k++) begin
            int n;
            lvl = ~lvl;
            n   = $urandom_range(1, 22);
            for (int j = 0; j < n; j++) cycle(lvl, "rand");
        end
        cycle(1'b0, "rand_end");
        cycle(1'b0, "rand_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
